// File: rtl/parallel_cnt_pkg.sv
// Shared constants and width helper for the parallel unary counter/accumulator.
package parallel_cnt_pkg;

    localparam int DEF_IWID = 16;
    localparam int DEF_AWID = 16;
    localparam int DEF_WIN  = 0;

    function automatic int owid(input int iwid);
        return $clog2(iwid + 1);
    endfunction

endpackage

// File: rtl/popcnt_tree.sv
// Combinational population count built as a recursive binary adder tree.
module popcnt_tree
    import parallel_cnt_pkg::*;
#(
    parameter  int W  = 8,
    localparam int CW = owid(W)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);

    if (W == 1) begin : g_leaf
        assign count = bits;
    end else begin : g_node
        localparam int LW  = W / 2;
        localparam int HW  = W - LW;
        localparam int LCW = owid(LW);
        localparam int HCW = owid(HW);

        logic [LCW-1:0] lo;
        logic [HCW-1:0] hi;

        popcnt_tree #(.W(LW)) u_lo (
            .bits  (bits[LW-1:0]),
            .count (lo)
        );

        popcnt_tree #(.W(HW)) u_hi (
            .bits  (bits[W-1:LW]),
            .count (hi)
        );

        assign count = CW'(lo) + CW'(hi);
    end

endmodule

// File: rtl/parallel_cnt_acc.sv
// Two-stage popcount pipeline feeding a windowed accumulator.
// Define PARALLEL_CNT_ACC_SAT_EN to clamp acc at its maximum instead of wrapping.
module parallel_cnt_acc
    import parallel_cnt_pkg::*;
#(
    parameter  int IWID = DEF_IWID,
    parameter  int AWID = DEF_AWID,
    parameter  int WIN  = DEF_WIN,
    localparam int OWID = owid(IWID)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [IWID-1:0] in,
    input  logic            clear,
    output logic            cnt_valid,
    output logic [OWID-1:0] cnt,
    output logic [AWID-1:0] acc,
    output logic            acc_done,
    output logic            acc_ovf
);

    localparam int LW  = IWID / 2;
    localparam int HW  = IWID - LW;
    localparam int LCW = owid(LW);
    localparam int HCW = owid(HW);
    localparam int SW  = AWID + 1;
    localparam int WCW = (WIN > 0) ? $clog2(WIN + 1) : 1;
    localparam logic [AWID-1:0] AMAX = '1;

    logic [LCW-1:0]  lo_pc;
    logic [LCW-1:0]  lo_q;
    logic [HCW-1:0]  hi_pc;
    logic [HCW-1:0]  hi_q;
    logic            s1_valid;
    logic [WCW-1:0]  wcnt;
    logic [AWID-1:0] base;
    logic [SW-1:0]   sum;
    logic [AWID-1:0] acc_nxt;
    logic            win_last;

    // The upper half gets the extra bit when IWID is odd.
    popcnt_tree #(.W(LW)) u_lo (
        .bits  (in[LW-1:0]),
        .count (lo_pc)
    );

    popcnt_tree #(.W(HW)) u_hi (
        .bits  (in[IWID-1:LW]),
        .count (hi_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                lo_q <= lo_pc;
                hi_q <= hi_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_valid <= 1'b0;
            cnt       <= '0;
        end else if (clear) begin
            cnt_valid <= 1'b0;
        end else begin
            cnt_valid <= s1_valid;
            if (s1_valid) begin
                cnt <= OWID'(lo_q) + OWID'(hi_q);
            end
        end
    end

    // A fresh window starts from zero rather than the previous total.
    always_comb begin
        base = acc;
        if ((WIN > 0) && (wcnt == '0)) begin
            base = '0;
        end
        sum      = {1'b0, base} + SW'(cnt);
        win_last = (WIN > 0) && (wcnt == WCW'(WIN - 1));
    end

`ifdef PARALLEL_CNT_ACC_SAT_EN
    assign acc_nxt = sum[AWID] ? AMAX : sum[AWID-1:0];
`else
    assign acc_nxt = sum[AWID-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            wcnt     <= '0;
            acc_done <= 1'b0;
            acc_ovf  <= 1'b0;
        end else if (clear) begin
            acc      <= '0;
            wcnt     <= '0;
            acc_done <= 1'b0;
            acc_ovf  <= 1'b0;
        end else begin
            acc_done <= 1'b0;
            if (cnt_valid) begin
                acc <= acc_nxt;
                if (sum[AWID]) begin
                    acc_ovf <= 1'b1;
                end
                if (win_last) begin
                    wcnt     <= '0;
                    acc_done <= 1'b1;
                end else if (WIN > 0) begin
                    wcnt <= wcnt + WCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_parallel_cnt_acc.sv
// Scoreboard bench for parallel_cnt_acc (IWID=16, AWID=8, WIN=4 plus a WIN=0 copy).
module tb_parallel_cnt_acc;

    localparam int IWID = 16;
    localparam int AWID = 8;
    localparam int WIN  = 4;
    localparam int OWID = 5;
    localparam int AMAX = (1 << AWID) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            clear = 1'b0;
    logic [IWID-1:0] din = '0;

    logic            cnt_valid, acc_done, acc_ovf;
    logic [OWID-1:0] cnt;
    logic [AWID-1:0] acc;
    logic            cnt_valid2, acc_done2, acc_ovf2;
    logic [OWID-1:0] cnt2;
    logic [AWID-1:0] acc2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int epoch = 0;
    int done2_cnt = 0;

    typedef struct {
        int cnt;
        int cyc;
        int acc;
        bit done;
        bit ovf;
        int ep;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    bit   pend = 1'b0;

    int macc = 0;
    int mwin = 0;
    bit movf = 1'b0;

    parallel_cnt_acc #(.IWID(IWID), .AWID(AWID), .WIN(WIN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (din),
        .clear     (clear),
        .cnt_valid (cnt_valid),
        .cnt       (cnt),
        .acc       (acc),
        .acc_done  (acc_done),
        .acc_ovf   (acc_ovf)
    );

    parallel_cnt_acc #(.IWID(IWID), .AWID(AWID), .WIN(0)) dut_nw (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (din),
        .clear     (clear),
        .cnt_valid (cnt_valid2),
        .cnt       (cnt2),
        .acc       (acc2),
        .acc_done  (acc_done2),
        .acc_ovf   (acc_ovf2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Monitor: pop on cnt_valid, check acc one cycle later.
    always @(negedge clk) begin
        if (pend && held.ep == epoch) begin
            chk("acc", acc, held.acc);
            chk("acc_done", acc_done, held.done);
            chk("acc_ovf", acc_ovf, held.ovf);
        end else begin
            chk("done_idle", acc_done, 0);
        end
        pend = 1'b0;
        if (acc_done2) done2_cnt++;
        if (cnt_valid) begin
            while (sb.size() > 0 && sb[0].ep != epoch) void'(sb.pop_front());
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                held = sb.pop_front();
                pend = 1'b1;
                chk("cnt", cnt, held.cnt);
                chk("latency", cyc, held.cyc);
            end
        end
    end

    task automatic beat(input bit v, input logic [IWID-1:0] d);
        exp_t e;
        int c;
        int s;
        in_valid = v;
        din = d;
        if (v) begin
            c = $countones(d);
            s = ((mwin == 0) ? 0 : macc) + c;
            if (s > AMAX) begin
                movf = 1'b1;
`ifdef PARALLEL_CNT_ACC_SAT_EN
                s = AMAX;
`else
                s = s % (AMAX + 1);
`endif
            end
            macc = s;
            mwin++;
            e.done = 1'b0;
            if (mwin == WIN) begin
                e.done = 1'b1;
                mwin = 0;
            end
            e.cnt = c;
            e.cyc = cyc + 2;
            e.acc = macc;
            e.ovf = movf;
            e.ep = epoch;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, '0);
    endtask

    task automatic model_reset();
        epoch++;
        macc = 0;
        mwin = 0;
        movf = 1'b0;
    endtask

    task automatic do_clear(input bit dirty);
        clear = 1'b1;
        in_valid = dirty;
        din = 16'hFFFF;
        @(posedge clk);
        #1;
        model_reset();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_valid", cnt_valid, 0);
        chk("clr_acc", acc, 0);
        chk("clr_ovf", acc_ovf, 0);
        chk("clr_done", acc_done, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        in_valid = 1'b1;
        din = 16'hFFFF;
        repeat (2) begin
            @(posedge clk);
            #1;
            model_reset();
            chk("rst_valid", cnt_valid, 0);
            chk("rst_cnt", cnt, 0);
            chk("rst_acc", acc, 0);
            chk("rst_done", acc_done, 0);
            chk("rst_ovf", acc_ovf, 0);
            chk("rst_valid2", cnt_valid2, 0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int live;
        int d2;

        do_reset();
        beat(1'b1, 16'hFFFF);
        idle(3);
        chk("rst_first_cnt", cnt, 16);

        do_clear(1'b0);
        beat(1'b1, 16'h0001);
        beat(1'b1, 16'hFFFF);
        idle(3);

        do_clear(1'b0);
        repeat (4) beat(1'b1, 16'h00FF);
        beat(1'b1, 16'h0003);
        idle(3);
        chk("win_restart", acc, 2);

        do_clear(1'b0);
        beat(1'b1, 16'hFFFF);
        beat(1'b1, 16'hFFFF);
        do_clear(1'b1);
        repeat (4) beat(1'b1, 16'h000F);
        idle(3);
        chk("win_after_clr", acc, 16);

        do_clear(1'b0);
        beat(1'b1, 16'h000F);
        beat(1'b0, 16'h000F);
        beat(1'b1, 16'h000F);
        beat(1'b0, 16'h000F);
        idle(3);
        chk("bubble_acc", acc, 8);

        // Clear lands on the edge that would complete the window.
        do_clear(1'b0);
        repeat (4) beat(1'b1, 16'h00FF);
        beat(1'b0, '0);
        do_clear(1'b0);
        idle(2);

        do_clear(1'b0);
        d2 = done2_cnt;
        repeat (17) beat(1'b1, 16'hFFFF);
        idle(4);
`ifdef PARALLEL_CNT_ACC_SAT_EN
        chk("nowin_acc", acc2, AMAX);
`else
        chk("nowin_acc", acc2, 16);
`endif
        chk("nowin_ovf", acc_ovf2, 1);
        chk("nowin_done", done2_cnt - d2, 0);
        chk("nowin_cnt", cnt2, 16);

        repeat (60) beat(1'($urandom_range(0, 1)), 16'($urandom));
        idle(5);

        live = 0;
        foreach (sb[i]) if (sb[i].ep == epoch) live++;
        chk("sb_drain", live, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
